vram_fill_arbiter: RTL

- Owns the single write port of the video memory and shares it between the CPU's WVM write path and a hardware fill engine.
- The fill engine writes one colour to a contiguous address range [First..Last]. It replaces software loops of the form WVM / ADD / BLE that currently take three instructions per pixel.
- Sits between the CPU core and the video RAM write side. The VGA read side is untouched.

---
 rtl/vram_fill_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/vram_fill_arbiter.sv
// Video memory write-port arbiter: CPU WVM writes share one port with a range-fill engine.
// Optional VRAM_FILL_ROUND_ROBIN_EN alternates the grant under contention instead of strict CPU priority.
module vram_fill_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iCpuWrEn,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuData,
  output logic              oCpuStall,
  input  logic              iFillStart,
  input  logic [ADDR_W-1:0] iFillFirst,
  input  logic [ADDR_W-1:0] iFillLast,
  input  logic [DATA_W-1:0] iFillColor,
  output logic              oFillBusy,
  output logic              oFillDone,
  output logic              oVmWrEn,
  output logic [ADDR_W-1:0] oVmAddr,
  output logic [DATA_W-1:0] oVmData
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last;
  logic [DATA_W-1:0] color;

  logic fill_req;
  logic cpu_gnt;
  logic fill_gnt;

  assign fill_req  = (state == FILL);
  assign oFillBusy = (state != IDLE);

`ifdef VRAM_FILL_ROUND_ROBIN_EN
  // rr_flag=1 means the CPU won the last contended cycle, so the fill wins the next one
  logic rr_flag;
  logic contend;

  assign contend   = iCpuWrEn && fill_req;
  assign cpu_gnt   = iCpuWrEn && !(contend && rr_flag);
  assign fill_gnt  = fill_req && !(contend && !rr_flag);
  assign oCpuStall = contend && rr_flag;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rr_flag <= 1'b0;
    else if (contend) rr_flag <= !rr_flag;
  end
`else
  assign cpu_gnt   = iCpuWrEn;
  assign fill_gnt  = fill_req && !iCpuWrEn;
  assign oCpuStall = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      last      <= '0;
      color     <= '0;
      oFillDone <= 1'b0;
      oVmWrEn   <= 1'b0;
      oVmAddr   <= '0;
      oVmData   <= '0;
    end else begin
      oFillDone <= 1'b0;
      oVmWrEn   <= cpu_gnt || fill_gnt;
      if (cpu_gnt) begin
        oVmAddr <= iCpuAddr;
        oVmData <= iCpuData;
      end else if (fill_gnt) begin
        oVmAddr <= ptr;
        oVmData <= color;
      end
      case (state)
        IDLE: if (iFillStart) begin
          ptr   <= iFillFirst;
          last  <= iFillLast;
          color <= iFillColor;
          state <= (iFillFirst <= iFillLast) ? FILL : DONE;
        end
        // compare before increment so a range ending at all-ones never wraps
        FILL: if (fill_gnt) begin
          if (ptr == last) state <= DONE;
          else ptr <= ptr + 1'b1;
        end
        DONE: begin
          oFillDone <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
